// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequencing stage in front of the 512x32 strobe-clocked RAM.
// Accepts one load/store at a time, drives the RAM strobes, address and write data, waits
// for ram_complete (bounded by TIMEOUT cycles), then returns a one-cycle done pulse.
// A one-cycle DONE state with both strobes low separates consecutive accesses.
//
// Ports:
//   clck, reset             clock, synchronous active-high reset
//   req, we, addr, wdata    request handshake, sampled only while idle
//   busy, done, rdata, err  status and result back to the datapath
//   ram_read, ram_write     RAM strobes (mutually exclusive, high only in ACCESS)
//   ram_addr, ram_data_in   registered address / write data to the RAM
//   ram_data_out            RAM read data
//   ram_complete            RAM completion flag
module mem_access_ctrl #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clck,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    input  logic              ram_complete
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    // Counter value on which a still-incomplete access gives up.
    localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

    state_e     state_q;
    logic [7:0] count_q;

    always_ff @(posedge clck) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        ram_addr    <= addr;
                        ram_data_in <= wdata;
                        ram_write   <= we;
                        ram_read    <= !we;
                        err         <= 1'b0;
                        count_q     <= '0;
                        busy        <= 1'b1;
                        state_q     <= StAccess;
                    end
                end
                StAccess: begin
                    // Completion takes priority over a coincident timeout.
                    if (ram_complete) begin
                        ram_read  <= 1'b0;
                        ram_write <= 1'b0;
                        if (ram_read) begin
                            rdata <= ram_data_out;
                        end
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else if (count_q == LastCount) begin
                        ram_read  <= 1'b0;
                        ram_write <= 1'b0;
                        err       <= 1'b1;
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        count_q <= count_q + 8'd1;
                    end
                end
                StDone: begin
                    // Strobes are already low here, giving the RAM its falling edge and gap.
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 8;

    logic              clck = 1'b0;
    logic              reset;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              ram_read;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;
    logic              ram_complete;

    always #5 clck = ~clck;

    mem_access_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clck        (clck),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .err         (err),
        .ram_read    (ram_read),
        .ram_write   (ram_write),
        .ram_addr    (ram_addr),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out),
        .ram_complete(ram_complete)
    );

    // RAM model: completes after ram_lat strobe cycles, or never when ram_dead is set.
    bit   [DATA_W-1:0] mem [512];
    logic [7:0]        ram_cnt = 8'd0;
    logic [7:0]        ram_lat;
    logic              ram_dead;

    assign ram_complete = (ram_read || ram_write) && !ram_dead && (ram_cnt == ram_lat - 8'd1);
    assign ram_data_out = mem[ram_addr];

    always @(posedge clck) begin
        if (!(ram_read || ram_write)) ram_cnt <= 8'd0;
        else                          ram_cnt <= ram_cnt + 8'd1;
        if (ram_write && ram_complete) mem[ram_addr] <= ram_data_in;
    end

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                width;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_bit(input string name, input logic act, input logic expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: per-cycle strobe rules, plus scoreboard pop on every done pulse.
    int                cyc = 0;
    int                width = 0;
    int                rise_cyc = 0;
    logic              busy_prev = 1'b0;
    logic              done_prev = 1'b0;
    logic              seen_we = 1'b0;
    logic [ADDR_W-1:0] seen_addr = '0;
    logic [DATA_W-1:0] seen_data = '0;
    exp_t              e;

    initial begin : monitor
        forever begin
            @(negedge clck);
            cyc++;
            check_bit("strobe_exclusive", ram_read && ram_write, 1'b0);
            if (done) check_bit("strobes_low_in_done", ram_read || ram_write, 1'b0);
            if (ram_read || ram_write) check_bit("strobe_only_when_busy", busy, 1'b1);
            if (done_prev) begin
                check_bit("done_single_cycle", done, 1'b0);
                check_bit("busy_low_after_done", busy, 1'b0);
            end
            if (busy && !busy_prev) rise_cyc = cyc;
            if (ram_read || ram_write) begin
                width++;
                seen_we   = ram_write;
                seen_addr = ram_addr;
                seen_data = ram_data_in;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1, required no pending access (t=%0t)",
                             $time);
                end else begin
                    e = exp_q.pop_front();
                    check_word("rdata", rdata, e.rdata);
                    check_bit("err", err, e.err);
                    check_word("strobe_width", width, e.width);
                    check_word("done_latency", cyc - rise_cyc, e.width);
                    check_bit("strobe_kind", seen_we, e.we);
                    check_word("ram_addr", 32'(seen_addr), 32'(e.addr));
                    if (e.we) check_word("ram_data_in", seen_data, e.wdata);
                end
                width = 0;
            end
            if (!busy) width = 0;
            busy_prev = busy;
            done_prev = done;
        end
    end

    // Waits for the edge on which busy rises; an expired bound is a failed check.
    task automatic wait_accept();
        bit   got = 0;
        logic b0;
        for (int i = 0; i < 40 && !got; i++) begin
            b0 = busy;
            @(posedge clck);
            #1;
            if (!b0 && busy) got = 1;
        end
        check_bit("request_accepted", got, 1'b1);
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clck);
            #1;
            if (!busy) got = 1;
        end
        check_bit("returned_to_idle", got, 1'b1);
    endtask

    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [DATA_W-1:0] er, input logic ee, input int wd,
                         input bit push);
        we    = w;
        addr  = a;
        wdata = d;
        req   = 1'b1;
        if (push) exp_q.push_back('{w, a, d, er, ee, wd});
        wait_accept();
        req = 1'b0;
    endtask

    // Held-request vectors: store/load alternating, expected rdata hand-computed.
    logic              v_we    [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [ADDR_W-1:0] v_addr  [6] = '{9'd5, 9'd5, 9'd6, 9'd6, 9'd5, 9'd5};
    logic [DATA_W-1:0] v_wdata [6] = '{32'h11, 32'h0, 32'h22, 32'h0, 32'h33, 32'h0};
    logic [DATA_W-1:0] v_rdata [6] = '{32'h0, 32'h11, 32'h11, 32'h22, 32'h22, 32'h33};

    initial begin : stimulus
        int last_acc;
        reset    = 1'b1;
        req      = 1'b0;
        we       = 1'b0;
        addr     = '0;
        wdata    = '0;
        ram_lat  = 8'd1;
        ram_dead = 1'b0;
        repeat (3) @(posedge clck);
        #1;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check_bit("rst_ram_read", ram_read, 1'b0);
        check_bit("rst_ram_write", ram_write, 1'b0);
        check_word("rst_rdata", rdata, 32'h0);
        check_word("rst_ram_addr", 32'(ram_addr), 32'h0);
        check_word("rst_ram_data_in", ram_data_in, 32'h0);
        reset = 1'b0;

        // 1: load from a fresh location.
        issue(1'b0, 9'd0, 32'h0, 32'h0, 1'b0, 1, 1'b1);
        wait_idle();

        // 2: store 86 then read it back.
        issue(1'b1, 9'd0, 32'd86, 32'h0, 1'b0, 1, 1'b1);
        wait_idle();
        issue(1'b0, 9'd0, 32'h0, 32'd86, 1'b0, 1, 1'b1);
        wait_idle();

        // 3: top address.
        issue(1'b1, 9'h1FF, 32'd2, 32'd86, 1'b0, 1, 1'b1);
        wait_idle();
        issue(1'b0, 9'h1FF, 32'h0, 32'd2, 1'b0, 1, 1'b1);
        wait_idle();
        issue(1'b0, 9'd0, 32'h0, 32'd86, 1'b0, 1, 1'b1);
        wait_idle();

        // 4: timeout, sticky err, cleared by next accepted request.
        ram_dead = 1'b1;
        issue(1'b0, 9'd3, 32'h0, 32'd86, 1'b1, 8, 1'b1);
        wait_idle();
        check_bit("err_sticky_idle", err, 1'b1);
        repeat (2) @(posedge clck);
        #1;
        check_bit("err_sticky_later", err, 1'b1);
        check_word("rdata_kept_after_timeout", rdata, 32'd86);
        ram_dead = 1'b0;
        issue(1'b0, 9'h1FF, 32'h0, 32'd2, 1'b0, 1, 1'b1);
        check_bit("err_cleared_on_accept", err, 1'b0);
        wait_idle();

        // 5: slow RAM, then reset on the third strobe cycle.
        ram_lat = 8'd5;
        issue(1'b0, 9'd0, 32'h0, 32'd86, 1'b0, 5, 1'b1);
        wait_idle();
        issue(1'b0, 9'h1FF, 32'h0, 32'h0, 1'b0, 5, 1'b0);
        @(posedge clck);
        @(posedge clck);
        #1;
        reset = 1'b1;
        @(posedge clck);
        #1;
        reset = 1'b0;
        check_bit("midrst_ram_read", ram_read, 1'b0);
        check_bit("midrst_ram_write", ram_write, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_done", done, 1'b0);
        check_bit("midrst_err", err, 1'b0);
        check_word("midrst_rdata", rdata, 32'h0);
        repeat (6) @(posedge clck);
        #1;
        ram_lat = 8'd1;

        // 6: req held high, alternating store/load, one acceptance every 3 cycles.
        last_acc = 0;
        for (int i = 0; i < 6; i++) begin
            we    = v_we[i];
            addr  = v_addr[i];
            wdata = v_wdata[i];
            req   = 1'b1;
            exp_q.push_back('{v_we[i], v_addr[i], v_wdata[i], v_rdata[i], 1'b0, 1});
            wait_accept();
            if (i > 0) check_word("accept_spacing", cyc - last_acc, 3);
            last_acc = cyc;
        end
        req = 1'b0;
        wait_idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clck);
        repeat (2) @(posedge clck);
        check_word("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
